// File: rtl/proc_ctrl_pkg.sv
// Shared state codes, opcodes and A-source encodings for the processor control unit.
// Execute-state codes are {1'b1, opcode} so decode is a direct cast.
package proc_ctrl_pkg;

   typedef enum logic [3:0] {
      S0  = 4'b0000,
      S1  = 4'b0001,
      S2  = 4'b0010,
      S3  = 4'b1000,
      S4  = 4'b1001,
      S5  = 4'b1010,
      S6  = 4'b1011,
      S7  = 4'b1100,
      S8  = 4'b1101,
      S9  = 4'b1110,
      S10 = 4'b1111
   } state_t;

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_IN    = 3'b100;
   localparam logic [2:0] OP_JZ    = 3'b101;
   localparam logic [2:0] OP_JPOS  = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   localparam logic [1:0] ASEL_ADD = 2'b00;
   localparam logic [1:0] ASEL_IN  = 2'b01;
   localparam logic [1:0] ASEL_MEM = 2'b10;

endpackage

// File: rtl/proc_enter_arm.sv
// Enter-switch handshake: one capture per low-to-high cycle of enter.
// With SINGLE_STEP_EN defined it also produces the rising-edge pulse of step.
module proc_enter_arm (
   input  logic i_clock,
   input  logic i_rst_n,
   input  logic i_enter,
   input  logic i_in_input,
   output logic o_capture
`ifdef SINGLE_STEP_EN
   ,
   input  logic i_step,
   output logic o_step_rise
`endif
);

   logic r_armed;

   assign o_capture = i_in_input & i_enter & r_armed;

   // Re-arm only once enter has been seen low, so a held switch loads A once.
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_armed <= 1'b1;
      end else if (o_capture) begin
         r_armed <= 1'b0;
      end else if (!i_enter) begin
         r_armed <= 1'b1;
      end
   end

`ifdef SINGLE_STEP_EN
   logic r_step_q;

   assign o_step_rise = i_step & ~r_step_q;

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_step_q <= 1'b0;
      end else begin
         r_step_q <= i_step;
      end
   end
`endif

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Control FSM for the 8-bit processor: start, fetch, decode, execute, with a retired-instruction count.
// Define SINGLE_STEP_EN to add the step port; S0 then waits for a rising edge of step.
//
// state | meaning
// S0    | start (0000)
// S1    | fetch: IR <= mem[PC], PC <= PC+1 (0001)
// S2    | decode (0010)
// S3    | LOAD  A <= mem[IR] (1000)
// S4    | STORE mem[IR] <= A (1001)
// S5    | ADD (1010)
// S6    | SUB (1011)
// S7    | INPUT, waits for capture (1100)
// S8    | JZ (1101)
// S9    | JPOS (1110)
// S10   | HALT until reset (1111)
module proc_ctrl_fsm
   import proc_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
`ifdef SINGLE_STEP_EN
   input  logic             step,
`endif
   input  logic             enter,
   input  logic [2:0]       ir_op,
   input  logic             aeq0,
   input  logic             apos,
   output logic             irload,
   output logic             pcload,
   output logic             jmpmux,
   output logic             meminst,
   output logic             memwr,
   output logic [1:0]       asel,
   output logic             aload,
   output logic             sub,
   output logic             halt,
   output logic [3:0]       showstate,
   output logic [CNT_W-1:0] icount
);

   state_t           r_state;
   logic [CNT_W-1:0] r_icount;
   logic [CNT_W-1:0] w_icount_inc;
   logic             w_capture;
   logic             w_go;

   proc_enter_arm u_arm (
      .i_clock    (clock),
      .i_rst_n    (reset),
      .i_enter    (enter),
      .i_in_input (r_state == S7),
      .o_capture  (w_capture)
`ifdef SINGLE_STEP_EN
      ,
      .i_step     (step),
      .o_step_rise(w_go)
`endif
   );

`ifndef SINGLE_STEP_EN
   assign w_go = 1'b1;
`endif

   assign w_icount_inc = (r_icount == {CNT_W{1'b1}}) ? r_icount : r_icount + CNT_W'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= S0;
         r_icount <= '0;
      end else begin
         case (r_state)
            S0: if (w_go) r_state <= S1;
            S1: r_state <= S2;
            S2: begin
               r_state <= state_t'({1'b1, ir_op});
               if (ir_op == OP_HALT) r_icount <= w_icount_inc;
            end
            S3, S4, S5, S6, S8, S9: begin
               r_state  <= S0;
               r_icount <= w_icount_inc;
            end
            S7: begin
               if (w_capture) begin
                  r_state  <= S0;
                  r_icount <= w_icount_inc;
               end
            end
            S10: r_state <= S10;
            default: r_state <= S0;
         endcase
      end
   end

   // Moore decode; only the jump pcload and INPUT aload look at inputs.
   always_comb begin
      irload  = 1'b0;
      pcload  = 1'b0;
      jmpmux  = 1'b0;
      meminst = 1'b0;
      memwr   = 1'b0;
      asel    = ASEL_ADD;
      aload   = 1'b0;
      sub     = 1'b0;
      halt    = 1'b0;
      case (r_state)
         S1: begin
            meminst = 1'b1;
            irload  = 1'b1;
            pcload  = 1'b1;
         end
         S2: meminst = 1'b1;
         S3: begin
            asel  = ASEL_MEM;
            aload = 1'b1;
         end
         S4: memwr = 1'b1;
         S5: aload = 1'b1;
         S6: begin
            aload = 1'b1;
            sub   = 1'b1;
         end
         S7: begin
            asel  = ASEL_IN;
            aload = w_capture;
         end
         S8: begin
            pcload = aeq0;
            jmpmux = 1'b1;
         end
         S9: begin
            pcload = apos;
            jmpmux = 1'b1;
         end
         S10: halt = 1'b1;
         default: ;
      endcase
   end

   assign showstate = r_state;
   assign icount    = r_icount;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed table-driven bench for proc_ctrl_fsm (default build), plus hand sequences for HALT and reset.
module tb_proc_ctrl_fsm;

   localparam logic [9:0] K_S0    = 10'b0000000000;
   localparam logic [9:0] K_S1    = 10'b1101000000;
   localparam logic [9:0] K_S2    = 10'b0001000000;
   localparam logic [9:0] K_LOAD  = 10'b0000010100;
   localparam logic [9:0] K_STORE = 10'b0000100000;
   localparam logic [9:0] K_ADD   = 10'b0000000100;
   localparam logic [9:0] K_SUB   = 10'b0000000110;
   localparam logic [9:0] K_JMP_T = 10'b0110000000;
   localparam logic [9:0] K_JMP_N = 10'b0010000000;
   localparam logic [9:0] K_IN_W  = 10'b0000001000;
   localparam logic [9:0] K_IN_C  = 10'b0000001100;
   localparam logic [9:0] K_HALT  = 10'b0000000001;

   typedef struct {
      logic       enter;
      logic [2:0] op;
      logic       z;
      logic       p;
      logic [3:0] st;
      logic [9:0] strb;
      int         ic;
   } vec_t;

   vec_t vq[$];

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enter = 1'b0;
   logic [2:0]  ir_op = 3'b000;
   logic        aeq0  = 1'b0;
   logic        apos  = 1'b0;
   logic        irload, pcload, jmpmux, meminst, memwr, aload, sub, halt;
   logic [1:0]  asel;
   logic [3:0]  showstate;
   logic [15:0] icount;

   logic        s_irload, s_pcload, s_jmpmux, s_meminst, s_memwr, s_aload, s_sub, s_halt;
   logic [1:0]  s_asel;
   logic [3:0]  s_showstate;
   logic [1:0]  s_icount;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   proc_ctrl_fsm #(.CNT_W(16)) dut (
      .clock(clock), .reset(reset), .enter(enter), .ir_op(ir_op), .aeq0(aeq0), .apos(apos),
      .irload(irload), .pcload(pcload), .jmpmux(jmpmux), .meminst(meminst), .memwr(memwr),
      .asel(asel), .aload(aload), .sub(sub), .halt(halt), .showstate(showstate), .icount(icount)
   );

   proc_ctrl_fsm #(.CNT_W(2)) dut_sat (
      .clock(clock), .reset(reset), .enter(enter), .ir_op(ir_op), .aeq0(aeq0), .apos(apos),
      .irload(s_irload), .pcload(s_pcload), .jmpmux(s_jmpmux), .meminst(s_meminst), .memwr(s_memwr),
      .asel(s_asel), .aload(s_aload), .sub(s_sub), .halt(s_halt), .showstate(s_showstate),
      .icount(s_icount)
   );

   function automatic logic [9:0] strobes();
      return {irload, pcload, jmpmux, meminst, memwr, asel, aload, sub, halt};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   task automatic push(input logic e, input logic [2:0] op, input logic z, input logic p,
                       input logic [3:0] st, input logic [9:0] strb, input int ic);
      vec_t v;
      v.enter = e; v.op = op; v.z = z; v.p = p; v.st = st; v.strb = strb; v.ic = ic;
      vq.push_back(v);
   endtask

   task automatic push_instr(input logic [2:0] op, input logic z, input logic p,
                             input logic [3:0] st, input logic [9:0] strb, input int ic);
      push(1'b0, op, z, p, 4'b0000, K_S0, ic);
      push(1'b0, op, z, p, 4'b0001, K_S1, ic);
      push(1'b0, op, z, p, 4'b0010, K_S2, ic);
      push(1'b0, op, z, p, st, strb, ic);
   endtask

   function automatic logic [31:0] sat(input int ic);
      return (ic > 3) ? 32'd3 : ic;
   endfunction

   logic [3:0] seq_st [5];
   logic       seq_al [5];

   initial begin
      push_instr(3'b000, 1'b0, 1'b0, 4'b1000, K_LOAD,  0);
      push_instr(3'b010, 1'b0, 1'b0, 4'b1010, K_ADD,   1);
      push_instr(3'b011, 1'b0, 1'b0, 4'b1011, K_SUB,   2);
      push_instr(3'b001, 1'b0, 1'b0, 4'b1001, K_STORE, 3);
      push_instr(3'b101, 1'b1, 1'b0, 4'b1101, K_JMP_T, 4);
      push_instr(3'b101, 1'b0, 1'b1, 4'b1101, K_JMP_N, 5);
      push_instr(3'b110, 1'b0, 1'b1, 4'b1110, K_JMP_T, 6);
      push_instr(3'b110, 1'b1, 1'b0, 4'b1110, K_JMP_N, 7);
      // INPUT: enter low 5 cycles, then high captures once
      push(1'b0, 3'b100, 1'b0, 1'b0, 4'b0000, K_S0, 8);
      push(1'b0, 3'b100, 1'b0, 1'b0, 4'b0001, K_S1, 8);
      push(1'b0, 3'b100, 1'b0, 1'b0, 4'b0010, K_S2, 8);
      for (int k = 0; k < 5; k++) push(1'b0, 3'b100, 1'b0, 1'b0, 4'b1100, K_IN_W, 8);
      push(1'b1, 3'b100, 1'b0, 1'b0, 4'b1100, K_IN_C, 8);
      // second INPUT with enter still high must wait for a fresh low-high
      push(1'b1, 3'b100, 1'b0, 1'b0, 4'b0000, K_S0, 9);
      push(1'b1, 3'b100, 1'b0, 1'b0, 4'b0001, K_S1, 9);
      push(1'b1, 3'b100, 1'b0, 1'b0, 4'b0010, K_S2, 9);
      push(1'b1, 3'b100, 1'b0, 1'b0, 4'b1100, K_IN_W, 9);
      push(1'b1, 3'b100, 1'b0, 1'b0, 4'b1100, K_IN_W, 9);
      push(1'b0, 3'b100, 1'b0, 1'b0, 4'b1100, K_IN_W, 9);
      push(1'b1, 3'b100, 1'b0, 1'b0, 4'b1100, K_IN_C, 9);
      // HALT counts on entry
      push(1'b0, 3'b111, 1'b0, 1'b0, 4'b0000, K_S0, 10);
      push(1'b0, 3'b111, 1'b0, 1'b0, 4'b0001, K_S1, 10);
      push(1'b0, 3'b111, 1'b0, 1'b0, 4'b0010, K_S2, 10);
      push(1'b0, 3'b111, 1'b0, 1'b0, 4'b1111, K_HALT, 11);

      // reset state
      #2;
      chk("reset state", {28'd0, showstate}, 32'h0);
      chk("reset strobes", {22'd0, strobes()}, 32'h0);
      chk("reset icount", {16'd0, icount}, 32'h0);
      @(posedge clock); #1;
      chk("reset held state", {28'd0, showstate}, 32'h0);
      @(posedge clock); #2;
      reset = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         enter = vq[i].enter;
         ir_op = vq[i].op;
         aeq0  = vq[i].z;
         apos  = vq[i].p;
         #1;
         chk($sformatf("vec%0d state", i), {28'd0, showstate}, {28'd0, vq[i].st});
         chk($sformatf("vec%0d strobes", i), {22'd0, strobes()}, {22'd0, vq[i].strb});
         chk($sformatf("vec%0d icount", i), {16'd0, icount}, vq[i].ic);
         chk($sformatf("vec%0d icount_sat", i), {30'd0, s_icount}, sat(vq[i].ic));
         @(posedge clock); #1;
      end

      // HALT hold: 20 cycles, count frozen
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("halt hold %0d state", k), {28'd0, showstate}, 32'hF);
         chk($sformatf("halt hold %0d halt", k), {31'd0, halt}, 32'h1);
         chk($sformatf("halt hold %0d icount", k), {16'd0, icount}, 32'd11);
         @(posedge clock); #1;
      end

      // asynchronous reset mid-hold
      #2;
      reset = 1'b0;
      #1;
      chk("async reset state", {28'd0, showstate}, 32'h0);
      chk("async reset halt", {31'd0, halt}, 32'h0);
      chk("async reset icount", {16'd0, icount}, 32'h0);
      @(posedge clock); #2;
      reset = 1'b1;
      ir_op = 3'b001;
      enter = 1'b0;
      #1;
      chk("store seq S0", {28'd0, showstate}, 32'h0);
      @(posedge clock); #1;
      chk("store seq S1", {28'd0, showstate}, 32'h1);
      @(posedge clock); #1;
      chk("store seq S2", {28'd0, showstate}, 32'h2);
      #2;
      reset = 1'b0;
      #1;
      chk("store reset state", {28'd0, showstate}, 32'h0);
      chk("store reset memwr", {31'd0, memwr}, 32'h0);
      ir_op = 3'b100;
      enter = 1'b1;
      @(posedge clock); #1;
      chk("store reset hold memwr", {31'd0, memwr}, 32'h0);
      #2;
      reset = 1'b1;

      // after reset armed is 1: INPUT with enter already high captures at once
      seq_st[0] = 4'b0000; seq_st[1] = 4'b0001; seq_st[2] = 4'b0010;
      seq_st[3] = 4'b1100; seq_st[4] = 4'b0000;
      seq_al[0] = 1'b0; seq_al[1] = 1'b0; seq_al[2] = 1'b0; seq_al[3] = 1'b1; seq_al[4] = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("post-reset seq %0d state", k), {28'd0, showstate}, {28'd0, seq_st[k]});
         chk($sformatf("post-reset seq %0d aload", k), {31'd0, aload}, {31'd0, seq_al[k]});
         chk($sformatf("post-reset seq %0d memwr", k), {31'd0, memwr}, 32'h0);
         @(posedge clock); #1;
      end
      chk("post-reset icount", {16'd0, icount}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
